md5_search_sequencer: RTL

//  Parametrised brute-force candidate sequencer for the MD5 cracking datapath: enumerates plaintext guesses
//  of growing length over a configurable character range, feeds each one to an external MD5 core through
//  a ready/start/valid handshake, and compares every returned digest with a target hash. Stops on a match
//  (found) or when the search space is used up (exhausted). Sits between the top-level control and the MD5 core.

---
 rtl/md5_search_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/md5_search_sequencer.sv
// md5_search_sequencer
//   Brute-force candidate sequencer for the MD5 cracking datapath. Enumerates
//   plaintext guesses of growing length over [CHAR_LO, CHAR_HI]. Each guess goes
//   to an external MD5 core over a ready/start/valid handshake. Every returned
//   digest is compared with a latched target hash. The search stops on a match
//   (found) or when the search space runs out (exhausted).
//
//   Optional feature: define MD5_GUESS_LIMIT_EN to add a guess_limit input.
//   When the limit is non-zero, the search ends as exhausted once that many
//   digests have been compared without a match.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           one-cycle pulse: begin a search (ignored while busy)
//   start_char      first character of the first guess (clamped into range)
//   stride          step added to the last character per guess (0 acts as 1)
//   target_hash     digest to find, sampled on an accepted start
//   guess_limit     (MD5_GUESS_LIMIT_EN only) max digests to compare, 0 = none
//   core_ready      MD5 core can accept a word
//   core_start      one-cycle pulse: word_out/word_len valid for the core
//   word_out        current guess, byte 0 = last character, unused bytes 0
//   word_len        current guess length
//   digest_valid    one-cycle pulse: digest holds MD5(word_out)
//   digest          digest from the core
//   busy            search in progress
//   found           match found (sticky until start/reset)
//   exhausted       space used up without a match (sticky until start/reset)
//   plaintext       matching guess (same packing as word_out)
//   plaintext_len   length of the matching guess
//   guess_count     digests compared since the last start, saturating
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for start
// ISSUE     | guess ready, waiting for core_ready to pulse core_start
// WAIT      | core busy with the guess, waiting for digest_valid
// FOUND     | digest matched, plaintext holds the guess, waiting for start
// EXHAUSTED | search space (or guess limit) used up, waiting for start

module md5_search_sequencer #(
   parameter int         MAX_LEN = 8,
   parameter logic [7:0] CHAR_LO = 8'h61,
   parameter logic [7:0] CHAR_HI = 8'h7A,
   localparam int        LW      = $clog2(MAX_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [7:0]             start_char,
   input  logic [2:0]             stride,
   input  logic [127:0]           target_hash,
`ifdef MD5_GUESS_LIMIT_EN
   input  logic [31:0]            guess_limit,
`endif
   input  logic                   core_ready,
   output logic                   core_start,
   output logic [8*MAX_LEN-1:0]   word_out,
   output logic [LW-1:0]          word_len,
   input  logic                   digest_valid,
   input  logic [127:0]           digest,
   output logic                   busy,
   output logic                   found,
   output logic                   exhausted,
   output logic [8*MAX_LEN-1:0]   plaintext,
   output logic [LW-1:0]          plaintext_len,
   output logic [31:0]            guess_count
);

   localparam int WW = 8 * MAX_LEN;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_FOUND,
      ST_EXHAUSTED
   } state_t;

   state_t         state;
   logic [127:0]   target_q;
   logic [2:0]     stride_q;      // already forced to >= 1
   logic [7:0]     first_char;
   logic [WW-1:0]  adv_word;
   logic [LW-1:0]  adv_len;
   logic           adv_exhaust;
   logic [31:0]    count_inc;
   logic           limit_hit;
   logic           match;

`ifdef MD5_GUESS_LIMIT_EN
   logic [31:0]    limit_q;
   assign limit_hit = (limit_q != 32'd0) && (count_inc >= limit_q);
`else
   assign limit_hit = 1'b0;
`endif

   assign first_char = ((start_char < CHAR_LO) || (start_char > CHAR_HI)) ? CHAR_LO : start_char;
   assign count_inc  = (&guess_count) ? guess_count : guess_count + 32'd1;
   assign match      = (digest == target_q);

   // Odometer advance of the current guess. Char 0 gets the stride, higher
   // chars get the ripple carry; a wrap drops the overshoot and restarts at
   // CHAR_LO. A carry out of the top char either grows the word (all chars
   // restart at CHAR_LO) or, at MAX_LEN, flags the end of the space while
   // leaving the last guess visible on word_out.
   always_comb begin
      logic       carry;
      logic [8:0] sum;
      adv_word    = word_out;
      adv_len     = word_len;
      adv_exhaust = 1'b0;
      carry       = 1'b0;
      sum         = 9'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(word_len)) begin
            if (i == 0) sum = {1'b0, word_out[7:0]} + {6'd0, stride_q};
            else        sum = {1'b0, word_out[8*i +: 8]} + {8'd0, carry};
            if (sum > {1'b0, CHAR_HI}) begin
               adv_word[8*i +: 8] = CHAR_LO;
               carry              = 1'b1;
            end else begin
               adv_word[8*i +: 8] = sum[7:0];
               carry              = 1'b0;
            end
         end
      end
      if (carry) begin
         if (word_len < LW'(MAX_LEN)) begin
            adv_len = word_len + LW'(1);
            for (int i = 0; i < MAX_LEN; i++) begin
               adv_word[8*i +: 8] = (i <= int'(word_len)) ? CHAR_LO : 8'h00;
            end
         end else begin
            adv_exhaust = 1'b1;
            adv_word    = word_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         target_q      <= '0;
         stride_q      <= 3'd1;
         core_start    <= 1'b0;
         word_out      <= '0;
         word_len      <= '0;
         busy          <= 1'b0;
         found         <= 1'b0;
         exhausted     <= 1'b0;
         plaintext     <= '0;
         plaintext_len <= '0;
         guess_count   <= '0;
`ifdef MD5_GUESS_LIMIT_EN
         limit_q       <= '0;
`endif
      end else begin
         core_start <= 1'b0;
         case (state)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
               if (start) begin
                  target_q      <= target_hash;
                  stride_q      <= (stride == 3'd0) ? 3'd1 : stride;
                  word_out      <= WW'(first_char);
                  word_len      <= LW'(1);
                  found         <= 1'b0;
                  exhausted     <= 1'b0;
                  plaintext     <= '0;
                  plaintext_len <= '0;
                  guess_count   <= '0;
                  busy          <= 1'b1;
`ifdef MD5_GUESS_LIMIT_EN
                  limit_q       <= guess_limit;
`endif
                  state         <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (core_ready) begin
                  core_start <= 1'b1;
                  state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (digest_valid) begin
                  guess_count <= count_inc;
                  if (match) begin
                     found         <= 1'b1;
                     busy          <= 1'b0;
                     plaintext     <= word_out;
                     plaintext_len <= word_len;
                     state         <= ST_FOUND;
                  end else if (adv_exhaust || limit_hit) begin
                     exhausted <= 1'b1;
                     busy      <= 1'b0;
                     state     <= ST_EXHAUSTED;
                  end else begin
                     word_out <= adv_word;
                     word_len <= adv_len;
                     state    <= ST_ISSUE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
